// File: rtl/synth_pkg.sv
// Shared encodings and helpers for the tone generator slice.
// Waveform selects, envelope states and the phase increment constant.
package synth_pkg;

    localparam logic [1:0] WAVE_SQUARE = 2'd0;
    localparam logic [1:0] WAVE_SAW    = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_OFF    = 2'd3;

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    // K = floor(2^(phase_w+8) / sample_hz), the per-Hz increment scaled by 256
    function automatic logic [31:0] calc_k(input int phase_w, input int sample_hz);
        logic [63:0] num;
        logic [63:0] den;
        num = 64'd1 << (phase_w + 8);
        den = 64'(sample_hz);
        return 32'(num / den);
    endfunction

endpackage

// File: rtl/tone_env.sv
// Attack/sustain/release envelope: state machine plus 8-bit amplitude.
// Gate edges are honoured every cycle; amplitude steps only on sample ticks.
module tone_env
    import synth_pkg::*;
#(
    parameter int ATK_STEP = 1,
    parameter int REL_STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       gate,
    output logic [7:0] amp,
    output env_state_t state
);

    env_state_t state_n;
    logic [7:0] amp_n;
    logic [8:0] up;
    logic [8:0] dn;
    logic [7:0] up_sat;
    logic [7:0] dn_sat;

    // 9-bit sums expose overflow/borrow for saturation
    assign up     = {1'b0, amp} + 9'(ATK_STEP);
    assign dn     = {1'b0, amp} - 9'(REL_STEP);
    assign up_sat = up[8] ? 8'hFF : up[7:0];
    assign dn_sat = dn[8] ? 8'h00 : dn[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ENV_IDLE;
            amp   <= 8'd0;
        end else begin
            state <= state_n;
            amp   <= amp_n;
        end
    end

    always_comb begin
        state_n = state;
        amp_n   = amp;
        unique case (state)
            ENV_IDLE: begin
                amp_n = 8'd0;
                if (gate) state_n = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (!gate) begin
                    state_n = ENV_RELEASE;
                end else if (tick) begin
                    amp_n = up_sat;
                    if (up_sat == 8'hFF) state_n = ENV_SUSTAIN;
                end
            end
            ENV_SUSTAIN: begin
                amp_n = 8'hFF;
                if (!gate) state_n = ENV_RELEASE;
            end
            ENV_RELEASE: begin
                if (gate) begin
                    state_n = ENV_ATTACK;
                end else if (tick) begin
                    amp_n = dn_sat;
                    if (dn_sat == 8'd0) state_n = ENV_IDLE;
                end
            end
            default: begin
                state_n = ENV_IDLE;
                amp_n   = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/tone_gen.sv
// Phase-accumulator oscillator with envelope, emitting signed 8-bit samples.
// Retunes only at phase wrap so frequency changes never tear a waveform cycle.
module tone_gen
    import synth_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int SAMPLE_HZ = 48000,
    parameter int PHASE_W   = 24,
    parameter int ATK_STEP  = 1,
    parameter int REL_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] freq,
    input  logic        gate,
    input  logic [1:0]  wave_sel,
    output logic [7:0]  sample,
    output logic        sample_valid,
    output logic        active
);

    localparam int          DIV = CLK_HZ / SAMPLE_HZ;
    localparam int          CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [31:0] K   = calc_k(PHASE_W, SAMPLE_HZ);

    logic [CW-1:0]        cnt;
    logic                 tick;
    logic [PHASE_W-1:0]   phase;
    logic [PHASE_W-1:0]   inc_pending;
    logic [PHASE_W-1:0]   inc_active;
    logic [PHASE_W:0]     sum;
    logic                 carry;
    logic [43:0]          prod_f;
    logic [PHASE_W-1:0]   inc_next;
    logic [7:0]           amp;
    env_state_t           state;
    logic                 start;
    logic [8:0]           p;
    logic [7:0]           tri_t;
    logic signed [7:0]    raw;
    logic signed [16:0]   mult;

    tone_env #(
        .ATK_STEP(ATK_STEP),
        .REL_STEP(REL_STEP)
    ) u_env (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .gate (gate),
        .amp  (amp),
        .state(state)
    );

    assign tick     = (cnt == CW'(DIV - 1));
    assign start    = (state == ENV_IDLE) && gate;
    assign sum      = {1'b0, phase} + {1'b0, inc_active};
    assign carry    = sum[PHASE_W];
    assign prod_f   = {32'd0, freq} * {12'd0, K};
    assign inc_next = prod_f[PHASE_W+7:8];
    assign active   = (state != ENV_IDLE);

    assign p     = phase[PHASE_W-1 -: 9];
    assign tri_t = p[8] ? (8'd255 - p[7:0]) : p[7:0];

    always_comb begin
        raw = 8'sd0;
        unique case (wave_sel)
            WAVE_SQUARE: raw = p[8] ? -8'sd127 : 8'sd127;
            WAVE_SAW:    raw = {~p[8], p[7:1]};
            WAVE_TRI:    raw = tri_t - 8'd128;
            WAVE_OFF:    raw = 8'sd0;
            default:     raw = 8'sd0;
        endcase
    end

    // Bits [15:8] of the signed product are the floor of the >>> 8
    assign mult = raw * $signed({1'b0, amp});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            sample_valid <= 1'b0;
            sample       <= 8'd0;
            phase        <= '0;
            inc_pending  <= '0;
            inc_active   <= '0;
        end else begin
            cnt          <= tick ? '0 : cnt + 1'b1;
            sample_valid <= tick;
            inc_pending  <= inc_next;
            if (state == ENV_IDLE || (tick && carry))
                inc_active <= inc_pending;
            if (start)
                phase <= '0;
            else if (tick)
                phase <= sum[PHASE_W-1:0];
            if (tick)
                sample <= mult[15:8];
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: timing, envelope, retune and reset behaviour.
// Fast instances use an 8-cycle sample period to keep envelope runs short.
module tb_tone_gen;
    import synth_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [11:0]       d_freq = 12'd440, f_freq = 12'd440, s_freq = 12'd440;
    logic              d_gate = 1'b0,    f_gate = 1'b0,    s_gate = 1'b0;
    logic [1:0]        d_wave = 2'd0,    f_wave = 2'd1,    s_wave = 2'd0;
    logic signed [7:0] d_sample, f_sample, s_sample;
    logic              d_valid, f_valid, s_valid;
    logic              d_active, f_active, s_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_gen u_def (
        .clk(clk), .rst(rst), .freq(d_freq), .gate(d_gate),
        .wave_sel(d_wave), .sample(d_sample),
        .sample_valid(d_valid), .active(d_active)
    );

    tone_gen #(.CLK_HZ(384000)) u_fast (
        .clk(clk), .rst(rst), .freq(f_freq), .gate(f_gate),
        .wave_sel(f_wave), .sample(f_sample),
        .sample_valid(f_valid), .active(f_active)
    );

    tone_gen #(.CLK_HZ(384000), .ATK_STEP(255), .REL_STEP(255)) u_sq (
        .clk(clk), .rst(rst), .freq(s_freq), .gate(s_gate),
        .wave_sel(s_wave), .sample(s_sample),
        .sample_valid(s_valid), .active(s_active)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int which, input int limit);
        int n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            step();
            n++;
            hit = (which == 0) ? d_valid : (which == 1) ? f_valid : s_valid;
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL timeout inst %0d got none exp valid", which);
        end
    endtask

    logic signed [7:0] s [1:120];
    int n;
    int first_neg;
    int next_pos;

    initial begin
        // reset
        #2 rst = 1'b1;
        #1;
        chk("rst_sample", d_sample, 0);
        chk("rst_valid", d_valid, 0);
        chk("rst_active", s_active, 0);
        step();
        step();
        rst = 1'b0;

        // 1: idle period and silent output
        n = 0;
        do begin step(); n++; end while (!d_valid && n < 3000);
        chk("period_first", n, 2083);
        chk("idle_sample", d_sample, 0);
        chk("idle_active", d_active, 0);
        n = 0;
        do begin step(); n++; end while (!d_valid && n < 3000);
        chk("period_second", n, 2083);
        chk("idle_sample2", d_sample, 0);

        // 2: square with instant attack
        wait_valid(2, 64);
        s_gate = 1'b1;
        step();
        chk("sq_active", s_active, 1);
        for (int k = 1; k <= 120; k++) begin
            wait_valid(2, 64);
            s[k] = s_sample;
            if (k == 1) chk("sq_phase1", u_sq.phase, 153790);
        end
        chk("sq_s1", s[1], 0);
        chk("sq_s2", s[2], 126);
        first_neg = 0;
        next_pos = 0;
        for (int k = 1; k <= 120; k++) begin
            if (first_neg == 0 && s[k] == -8'sd127) first_neg = k;
            if (first_neg != 0 && next_pos == 0 && s[k] == 8'sd126) next_pos = k;
        end
        chk("sq_first_neg", first_neg, 56);
        chk("sq_next_pos", next_pos, 111);
        chk("sq_neg_val", s[110], -127);

        // 3: envelope ramp with unit steps
        wait_valid(1, 64);
        f_gate = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            wait_valid(1, 64);
            if (k == 1) chk("env_amp1", u_fast.amp, 1);
            if (k == 254) chk("env_amp254", u_fast.amp, 254);
            if (k == 254) chk("env_st254", u_fast.state, ENV_ATTACK);
            if (k == 255) chk("env_amp255", u_fast.amp, 255);
            if (k == 255) chk("env_st255", u_fast.state, ENV_SUSTAIN);
        end
        f_gate = 1'b0;
        step();
        chk("rel_state", u_fast.state, ENV_RELEASE);
        chk("rel_amp0", u_fast.amp, 255);
        for (int k = 1; k <= 100; k++) wait_valid(1, 64);
        chk("rel_amp100", u_fast.amp, 155);

        // 4: retrigger during release
        f_gate = 1'b1;
        step();
        chk("retrig_state", u_fast.state, ENV_ATTACK);
        chk("retrig_amp", u_fast.amp, 155);
        chk("retrig_phase", u_fast.phase, 11184352);
        wait_valid(1, 64);
        chk("retrig_amp1", u_fast.amp, 156);
        f_gate = 1'b0;
        for (int k = 1; k <= 155; k++) wait_valid(1, 64);
        chk("tail_amp1", u_fast.amp, 1);
        chk("tail_active", f_active, 1);
        wait_valid(1, 64);
        chk("tail_amp0", u_fast.amp, 0);
        chk("tail_idle", f_active, 0);

        // 5: retune waits for phase wrap
        f_gate = 1'b1;
        for (int k = 1; k <= 10; k++) wait_valid(1, 64);
        f_freq = 12'd880;
        step();
        step();
        step();
        chk("rt_pending", u_fast.inc_pending, 307580);
        chk("rt_hold", u_fast.inc_active, 153790);
        for (int k = 11; k <= 111; k++) begin
            wait_valid(1, 64);
            if (k == 109) chk("rt_hold109", u_fast.inc_active, 153790);
            if (k == 110) chk("rt_new110", u_fast.inc_active, 307580);
            if (k == 110) chk("rt_phase110", u_fast.phase, 139684);
            if (k == 111) chk("rt_phase111", u_fast.phase, 447264);
            if (k == 111) chk("rt_saw111", f_sample, -55);
        end
        f_wave = 2'd3;
        wait_valid(1, 64);
        chk("off_s1", f_sample, 0);
        wait_valid(1, 64);
        chk("off_s2", f_sample, 0);

        // 5b: freq=0 freezes phase, triangle at p=0
        s_freq = 12'd0;
        s_wave = 2'd2;
        s_gate = 1'b0;
        wait_valid(2, 64);
        wait_valid(2, 64);
        chk("f0_idle", s_active, 0);
        s_gate = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_valid(2, 64);
            if (k == 1) chk("f0_s1", s_sample, 0);
            if (k == 2) chk("f0_s2", s_sample, -128);
            if (k == 5) chk("f0_s5", s_sample, -128);
        end
        chk("f0_phase", u_sq.phase, 0);
        chk("pre_rst_active", s_active, 1);

        // 6: async reset mid-note
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_sample", s_sample, 0);
        chk("arst_active", s_active, 0);
        chk("arst_amp", u_sq.amp, 0);
        chk("arst_state", u_sq.state, ENV_IDLE);
        chk("arst_fast_sample", f_sample, 0);
        step();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Sound source stage that sits directly downstream of the switch-to-frequency block.
- Consumes the 12-bit note frequency in Hz and a gate (note-on) level.
- Produces a signed 8-bit audio sample stream at a fixed sample rate, using a phase-accumulator oscillator shaped by an attack/sustain/release amplitude envelope.
- Feeds the output DAC/PWM stage.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
SAMPLE_HZ, 48000, output sample rate in Hz; DIV = CLK_HZ/SAMPLE_HZ (floor) = 2083
PHASE_W, 24, phase accumulator width
ATK_STEP, 1, amplitude increment per sample tick in ATTACK (1..255)
REL_STEP, 1, amplitude decrement per sample tick in RELEASE (1..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
freq  input  12  note frequency in Hz, unsigned; sampled every cycle
gate  input  1  note on (1) / off (0), level-sensitive
wave_sel  input  2  0 square, 1 saw, 2 triangle, 3 silence
sample  output  8  signed audio sample
sample_valid  output  1  one-cycle strobe, high on the cycle sample updates
active  output  1  high whenever envelope state != IDLE

Behaviour:
- Reset (async, while rst=1): sample=0, sample_valid=0, active=0; phase=0, amp=0, inc_active=0, tick counter=0, state=IDLE.
- Tick counter counts 0..DIV-1 and wraps. tick = (count==DIV-1). sample_valid is registered and equals tick delayed by one edge, i.e. one pulse every DIV cycles. First pulse is DIV cycles after rst deasserts.
- Increment:
  - K = floor(2^(PHASE_W+8)/SAMPLE_HZ) = 89478.
  - inc_pending = (freq*K)>>8, registered one cycle after freq changes. freq=440 -> 153790.
  - Product width is 12+17 bits, no overflow; result is truncated to PHASE_W bits.
- Glitch-free retune: inc_active <= inc_pending
  - every cycle while state==IDLE;
  - on a tick where phase+inc_active carries out of PHASE_W bits.
  - Otherwise inc_active holds, so a mid-cycle freq change takes effect only at the next wrap.
- Phase: on tick, phase <= (phase+inc_active) mod 2^PHASE_W. On IDLE->ATTACK, phase <= 0. freq=0 freezes phase.
- Raw waveform, from p = phase[PHASE_W-1:PHASE_W-9]:
  - square: +127 if MSB=0, else -127.
  - saw: {~p[8], p[7:1]} as signed, range -128..127.
  - triangle: t = MSB ? 255-p[7:0] : p[7:0], raw = t-128.
  - silence: 0.
- Output: on tick, sample <= (raw * {1'b0,amp}) >>> 8 (signed, arithmetic shift, floor). It uses the phase and amp values held before the tick edge.
- Envelope FSM, advancing only on tick unless noted:
  - IDLE: gate=1 -> ATTACK; this transition is checked every cycle, not only on tick. amp=0.
  - ATTACK: amp <= min(amp+ATK_STEP, 255); reaching 255 -> SUSTAIN; gate=0 -> RELEASE (checked every cycle).
  - SUSTAIN: amp=255; gate=0 -> RELEASE (every cycle).
  - RELEASE: amp <= max(amp-REL_STEP, 0); reaching 0 -> IDLE; gate=1 -> ATTACK, continuing from the current amp with no phase reset.
- Simultaneous events:
  - When gate changes on a tick cycle, the transition wins and the new state's step applies from the next tick.
  - Saturating arithmetic: amp never wraps.
- active = (state != IDLE), registered with the state.
- rst mid-note: immediate return to the reset values above; no release tail.

Decomposition:
- synth_pkg holds:
  - wave_sel encodings (WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_OFF);
  - the envelope state enum (ENV_IDLE, ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE);
  - the function computing K from PHASE_W/SAMPLE_HZ.
- One sub-module, tone_env: the envelope FSM plus amp register. Inputs clk, rst, tick, gate; outputs amp[7:0], state.

Test Plan:
1. Reset/idle: rst pulse, gate=0, freq=440 -> sample=0 every valid, active=0, sample_valid period exactly 2083 cycles.
2. Square, ATK_STEP=255: freq=440, wave_sel=0, gate=1 -> active=1; phase=153790 after first tick; samples +126 until phase MSB sets (~55 samples), then -127; sign-change spacing 54/55 samples.
3. Envelope ramp with defaults: gate=1 for 300 ticks then 0 -> amp 1,2,...,255 reached at tick 255, SUSTAIN; after gate drop amp falls by 1 per tick; IDLE and active=0 255 ticks later.
4. Retrigger in RELEASE: gate=0 at amp=255, gate=1 after 100 ticks (amp=155) -> ATTACK resumes from 155, no phase reset, sample sign pattern continuous.
5. Glitch-free retune: playing saw at 440, freq->880 mid-cycle -> increment stays 153790 until the next phase wrap, then 307580; no discontinuity except at wrap. Both wave_sel=3 and freq=0 -> sample=0 / constant.
6. Async reset mid-note in SUSTAIN -> sample, amp, and state zero immediately, without waiting for a clock edge.
